// File: rtl/zynq_design_pkg.sv
// zynq_design_pkg: address map, GPIO reset values, AXI response codes and controller states
package zynq_design_pkg;
  localparam logic [31:0] GPIO_BASE_DEF = 32'h4120_0000;
  localparam logic [31:0] BRAM_BASE_DEF = 32'h4000_0000;
  localparam logic [15:0] GPIO_DATA_OFF = 16'h0000;
  localparam logic [15:0] GPIO_TRI_OFF = 16'h0004;
  localparam logic [31:0] GPIO_DATA_RST = 32'h0000_0000;
  localparam logic [31:0] GPIO_TRI_RST = 32'hFFFF_FFFF;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, WRESP, RWAIT, RDATA} state_t;
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/zynq_design_bram.sv
// zynq_design_bram: single-port synchronous-read RAM, 32-bit words with byte enables
module zynq_design_bram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/zynq_design.sv
// zynq_design: GP0 AXI4-Lite slave with LED GPIO and BRAM; define ZYNQ_DESIGN_DECERR_EN for DECERR on unmapped access
module zynq_design
  import zynq_design_pkg::*;
#(
  parameter logic [31:0] GPIO_BASE = GPIO_BASE_DEF,
  parameter logic [31:0] BRAM_BASE = BRAM_BASE_DEF,
  parameter int BRAM_AW = 11,
  parameter int GPIO_W = 4
) (
  input  logic              FIXED_IO_ps_clk,
  input  logic              FIXED_IO_ps_porb,
  input  logic              FIXED_IO_ps_srstb,
  input  logic              fpga_soft_rst,
  input  logic [31:0]       s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [31:0]       s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [GPIO_W-1:0] led_4bits_tri_o
);
`ifdef ZYNQ_DESIGN_DECERR_EN
  localparam logic [1:0] UNMAP_RESP = RESP_DECERR;
`else
  localparam logic [1:0] UNMAP_RESP = RESP_OKAY;
`endif
  localparam logic [31:0] BRAM_BYTES = 32'd4 << BRAM_AW;
  function automatic logic bram_hit(input logic [31:0] a);
    return a >= BRAM_BASE && (a - BRAM_BASE) < BRAM_BYTES;
  endfunction
  function automatic logic gpio_hit(input logic [31:0] a);
    return a[31:16] == GPIO_BASE[31:16];
  endfunction
  state_t state;
  logic [GPIO_W-1:0] gpio_data, gpio_tri;
  logic [31:0] raddr, wmask, bram_q, rd_val;
  logic [3:0] bram_we;
  logic [BRAM_AW-1:0] bram_addr;
  logic srst, aw_hs, ar_hs;
  logic [1:0] wr_resp, rd_resp;
  always_comb begin
    srst = !FIXED_IO_ps_srstb || fpga_soft_rst;
    aw_hs = state == IDLE && s_axi_awready && s_axi_awvalid && s_axi_wvalid;
    ar_hs = state == IDLE && s_axi_arready && s_axi_arvalid;
    wmask = strb_mask(s_axi_wstrb);
    bram_we = (aw_hs && !srst && bram_hit(s_axi_awaddr)) ? s_axi_wstrb : 4'b0;
    bram_addr = s_axi_awready ? s_axi_awaddr[BRAM_AW+1:2] : s_axi_araddr[BRAM_AW+1:2];
    wr_resp = (bram_hit(s_axi_awaddr) || gpio_hit(s_axi_awaddr)) ? RESP_OKAY : UNMAP_RESP;
    rd_resp = (bram_hit(raddr) || gpio_hit(raddr)) ? RESP_OKAY : UNMAP_RESP;
    rd_val = bram_hit(raddr) ? bram_q :
             (gpio_hit(raddr) && raddr[15:0] == GPIO_DATA_OFF) ? 32'(gpio_data) :
             (gpio_hit(raddr) && raddr[15:0] == GPIO_TRI_OFF) ? 32'(gpio_tri) : 32'h0;
  end
  zynq_design_bram #(.AW(BRAM_AW)) u_bram (
    .clk(FIXED_IO_ps_clk), .we(bram_we), .addr(bram_addr), .wdata(s_axi_wdata), .rdata(bram_q)
  );
  always_ff @(posedge FIXED_IO_ps_clk or negedge FIXED_IO_ps_porb) begin
    if (!FIXED_IO_ps_porb) begin
      state <= IDLE;
      {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} <= '0;
      {s_axi_bresp, s_axi_rresp, s_axi_rdata, raddr} <= '0;
      gpio_data <= GPIO_DATA_RST[GPIO_W-1:0];
      gpio_tri <= GPIO_TRI_RST[GPIO_W-1:0];
    end else if (srst) begin
      state <= IDLE;
      {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} <= '0;
      {s_axi_bresp, s_axi_rresp, s_axi_rdata, raddr} <= '0;
      gpio_data <= GPIO_DATA_RST[GPIO_W-1:0];
      gpio_tri <= GPIO_TRI_RST[GPIO_W-1:0];
    end else begin
      case (state)
        IDLE:
          if (aw_hs) begin
            {s_axi_awready, s_axi_wready} <= 2'b00;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp <= wr_resp;
            if (gpio_hit(s_axi_awaddr) && s_axi_awaddr[15:0] == GPIO_DATA_OFF)
              gpio_data <= (gpio_data & ~wmask[GPIO_W-1:0]) | (s_axi_wdata[GPIO_W-1:0] & wmask[GPIO_W-1:0]);
            if (gpio_hit(s_axi_awaddr) && s_axi_awaddr[15:0] == GPIO_TRI_OFF)
              gpio_tri <= s_axi_wdata[GPIO_W-1:0];
            state <= WRESP;
          end else if (ar_hs) begin
            s_axi_arready <= 1'b0;
            raddr <= s_axi_araddr;
            state <= RWAIT;
          end else if (!s_axi_awready && !s_axi_arready) begin
            // write wins when both channels are valid in the same cycle
            if (s_axi_awvalid && s_axi_wvalid) {s_axi_awready, s_axi_wready} <= 2'b11;
            else if (s_axi_arvalid) s_axi_arready <= 1'b1;
          end
        WRESP:
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state <= IDLE;
          end
        RWAIT: begin
          s_axi_rdata <= rd_val;
          s_axi_rresp <= rd_resp;
          s_axi_rvalid <= 1'b1;
          state <= RDATA;
        end
        RDATA:
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
  assign led_4bits_tri_o = gpio_data;
endmodule

// File: tb/tb_zynq_design.sv
// tb_zynq_design: directed AXI4-Lite stimulus with a read scoreboard queue and immediate-assertion checks
module tb_zynq_design;
  logic tb_ACLK = 1'b0;
  logic porb = 1'b0, srstb = 1'b1, fpga_soft_rst = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [3:0] led;
  int total = 0, bad = 0;
  typedef struct packed {logic [31:0] d; logic [1:0] r;} exp_t;
  exp_t exp_q[$];
`ifdef ZYNQ_DESIGN_DECERR_EN
  localparam logic [1:0] UNMAP = 2'b11;
`else
  localparam logic [1:0] UNMAP = 2'b00;
`endif

  always #5 tb_ACLK = ~tb_ACLK;

  zynq_design dut (
    .FIXED_IO_ps_clk(tb_ACLK), .FIXED_IO_ps_porb(porb), .FIXED_IO_ps_srstb(srstb),
    .fpga_soft_rst(fpga_soft_rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .led_4bits_tri_o(led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp, input logic [3:0] exp_led);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge tb_ACLK);
    while (!awready && n < 20) begin @(negedge tb_ACLK); n++; end
    chk("aw_ready", awready, 1);
    chk("w_ready", wready, 1);
    chk("ar_low_on_write", arready, 0);
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_n1", bvalid, 1);
    chk("bresp", bresp, exp_resp);
    chk("led_n1", led, exp_led);
    bready = 1'b1;
    @(posedge tb_ACLK); #1;
    bready = 1'b0;
    chk("bvalid_clr", bvalid, 0);
  endtask

  task automatic do_read();
    int n = 0;
    exp_t e;
    @(negedge tb_ACLK);
    while (!arready && n < 20) begin @(negedge tb_ACLK); n++; end
    chk("ar_ready", arready, 1);
    @(posedge tb_ACLK); #1;
    arvalid = 1'b0;
    @(negedge tb_ACLK);
    chk("rvalid_n1", rvalid, 0);
    @(negedge tb_ACLK);
    chk("rvalid_n2", rvalid, 1);
    e = exp_q.pop_front();
    chk("rdata", rdata, e.d);
    chk("rresp", rresp, e.r);
    rready = 1'b1;
    @(posedge tb_ACLK); #1;
    rready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    araddr = a; arvalid = 1'b1;
    exp_q.push_back('{d: d, r: r});
    do_read();
  endtask

  initial begin
    repeat (20) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("rst_led", led, 4'h0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    porb = 1'b1;
    repeat (2) @(posedge tb_ACLK); #1;
    axi_read(32'h4120_0004, 32'h0000_000F, 2'b00);
    axi_write(32'h4120_0000, 32'hFFFF_FFFF, 4'hF, 2'b00, 4'hF);
    axi_read(32'h4120_0000, 32'h0000_000F, 2'b00);
    axi_write(32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 2'b00, 4'hF);
    axi_read(32'h4000_0000, 32'hDEAD_BEEF, 2'b00);
    axi_write(32'h4000_0000, 32'h0000_0011, 4'b0001, 2'b00, 4'hF);
    axi_read(32'h4000_0000, 32'hDEAD_BE11, 2'b00);
    axi_read(32'h5000_0000, 32'h0, UNMAP);
    axi_write(32'h5000_0000, 32'h1234_5678, 4'hF, UNMAP, 4'hF);
    axi_write(32'h4120_0000, 32'h0000_0005, 4'b0000, 2'b00, 4'hF);
    araddr = 32'h4000_0004; arvalid = 1'b1;
    exp_q.push_back('{d: 32'hCAFE_0123, r: 2'b00});
    axi_write(32'h4000_0004, 32'hCAFE_0123, 4'hF, 2'b00, 4'hF);
    do_read();
    @(negedge tb_ACLK);
    fpga_soft_rst = 1'b1;
    @(negedge tb_ACLK);
    fpga_soft_rst = 1'b0;
    chk("soft_rst_led", led, 4'h0);
    axi_read(32'h4000_0004, 32'hCAFE_0123, 2'b00);
    axi_read(32'h4000_0000, 32'hDEAD_BE11, 2'b00);
    axi_read(32'h4120_0004, 32'h0000_000F, 2'b00);
    axi_write(32'h4120_0000, 32'h0000_000A, 4'hF, 2'b00, 4'hA);
    @(negedge tb_ACLK);
    srstb = 1'b0;
    @(negedge tb_ACLK);
    srstb = 1'b1;
    chk("srstb_led", led, 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
